// File: rtl/int_ctl_gen.sv
// Prioritised interrupt controller: edge/level pending flags, two-level priority arbitration, in-service tracking.
// Define INT_CTL_NEST_EN to let a high-priority source pre-empt a low-priority one that is in service.
module int_ctl_gen #(
  parameter int N_SRC = 5,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ea,
  input  logic [N_SRC-1:0] ie,
  input  logic [N_SRC-1:0] ip,
  input  logic [N_SRC-1:0] it_mode,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             int_ack,
  input  logic             reti,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  output logic [N_SRC-1:0] pend,
  output logic [1:0]       in_svc
);

  logic [N_SRC-1:0] irq_d_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [1:0]       in_svc_q, in_svc_d;
  logic             int_req_q, int_req_d;
  logic [VEC_W-1:0] int_vec_q, int_vec_d;

  logic             ack_acc;
  logic [N_SRC-1:0] clr_mask;
  logic [1:0]       svc_after_reti;
  logic [N_SRC-1:0] cand;
  logic             hi_found, lo_found, win_any, eligible;
  logic [VEC_W-1:0] hi_idx, lo_idx, win_idx;
`ifdef INT_CTL_NEST_EN
  logic             ack_hi;
`endif

  always_comb begin
    ack_acc  = int_ack & int_req_q;
    clr_mask = '0;
`ifdef INT_CTL_NEST_EN
    ack_hi   = 1'b0;
`endif
    for (int i = 0; i < N_SRC; i++) begin
      if (int_vec_q == VEC_W'(i)) begin
        clr_mask[i] = ack_acc & it_mode[i];
`ifdef INT_CTL_NEST_EN
        ack_hi      = ip[i];
`endif
      end
    end

    // reti retires the deepest nesting level before the new ack is recorded
    svc_after_reti = in_svc_q;
    if (reti) begin
      if (in_svc_q[1])      svc_after_reti[1] = 1'b0;
      else if (in_svc_q[0]) svc_after_reti[0] = 1'b0;
    end
    in_svc_d = svc_after_reti;
`ifdef INT_CTL_NEST_EN
    if (ack_acc) begin
      if (ack_hi) in_svc_d[1] = 1'b1;
      else        in_svc_d[0] = 1'b1;
    end
`else
    if (ack_acc) in_svc_d[0] = 1'b1;
    in_svc_d[1] = 1'b0;
`endif

    // A fresh edge in the ack cycle re-sets the flag after the clear
    for (int i = 0; i < N_SRC; i++) begin
      if (it_mode[i]) pend_d[i] = (irq_in[i] & ~irq_d_q[i]) | (pend_q[i] & ~clr_mask[i]);
      else            pend_d[i] = irq_in[i];
    end

    // Arbitrate on registered flags (fixed 2-cycle latency), minus the one just acked
    cand     = pend_q & ~clr_mask & ie & {N_SRC{ea}};
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i] & ip[i]) begin
        hi_found = 1'b1;
        hi_idx   = VEC_W'(i);
      end
      if (cand[i] & ~ip[i]) begin
        lo_found = 1'b1;
        lo_idx   = VEC_W'(i);
      end
    end
    win_any = hi_found | lo_found;
    win_idx = hi_found ? hi_idx : lo_idx;
`ifdef INT_CTL_NEST_EN
    eligible = hi_found ? ~in_svc_d[1] : (in_svc_d == 2'b00);
`else
    eligible = ~in_svc_d[0];
`endif
    int_req_d = win_any & eligible;
    int_vec_d = int_req_d ? win_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_d_q   <= '0;
      pend_q    <= '0;
      in_svc_q  <= 2'b00;
      int_req_q <= 1'b0;
      int_vec_q <= '0;
    end else begin
      irq_d_q   <= irq_in;
      pend_q    <= pend_d;
      in_svc_q  <= in_svc_d;
      int_req_q <= int_req_d;
      int_vec_q <= int_vec_d;
    end
  end

  assign int_req = int_req_q;
  assign int_vec = int_vec_q;
  assign pend    = pend_q;
  assign in_svc  = in_svc_q;

endmodule

// File: tb/tb_int_ctl_gen.sv
// Bench for int_ctl_gen: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model.
module tb_int_ctl_gen;
  localparam int N_SRC = 5;
  localparam int VEC_W = 3;
`ifdef INT_CTL_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             ea = 1'b0;
  logic [N_SRC-1:0] ie = '0, ip = '0, it_mode = '0, irq_in = '0;
  logic             int_ack = 1'b0, reti = 1'b0;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic [N_SRC-1:0] pend;
  logic [1:0]       in_svc;

  int_ctl_gen #(.N_SRC(N_SRC), .VEC_W(VEC_W)) dut (
    .clk(clk), .rst_n(rst_n), .ea(ea), .ie(ie), .ip(ip), .it_mode(it_mode),
    .irq_in(irq_in), .int_ack(int_ack), .reti(reti),
    .int_req(int_req), .int_vec(int_vec), .pend(pend), .in_svc(in_svc)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit m_pend[N_SRC];
  bit m_last[N_SRC];
  int m_depth_hi, m_depth_lo;
  bit m_req;
  int m_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit accepted;
    int av, best;
    bit best_hi, ok;
    bit avail[N_SRC];
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) begin m_pend[i] = 0; m_last[i] = 0; end
      m_depth_hi = 0; m_depth_lo = 0; m_req = 0; m_vec = 0;
      return;
    end
    accepted = int_ack && m_req;
    av = m_vec;
    if (reti) begin
      if (m_depth_hi > 0) m_depth_hi = 0;
      else if (m_depth_lo > 0) m_depth_lo = 0;
    end
    if (accepted) begin
      if (NEST && ip[av]) m_depth_hi = 1;
      else m_depth_lo = 1;
    end
    for (int i = 0; i < N_SRC; i++) begin
      avail[i] = m_pend[i] && !(accepted && av == i && it_mode[i]);
      if (it_mode[i]) m_pend[i] = (irq_in[i] && !m_last[i]) || avail[i];
      else m_pend[i] = irq_in[i];
      m_last[i] = irq_in[i];
    end
    best = -1; best_hi = 0;
    for (int i = 0; i < N_SRC; i++)
      if (best < 0 && avail[i] && ie[i] && ea && ip[i]) begin best = i; best_hi = 1; end
    for (int i = 0; i < N_SRC; i++)
      if (best < 0 && avail[i] && ie[i] && ea) best = i;
    if (best < 0) ok = 0;
    else if (!NEST) ok = (m_depth_lo == 0);
    else if (best_hi) ok = (m_depth_hi == 0);
    else ok = (m_depth_hi == 0 && m_depth_lo == 0);
    m_req = ok;
    m_vec = ok ? best : 0;
  endtask

  // one clock: model advances on the edge, outputs compared 1 time unit later
  task automatic tick();
    logic [N_SRC-1:0] mp;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N_SRC; i++) mp[i] = m_pend[i];
    check("int_req", 32'(int_req), 32'(m_req));
    check("pend", 32'(pend), 32'(mp));
    check("in_svc", 32'(in_svc), {30'd0, 1'(m_depth_hi), 1'(m_depth_lo)});
    if (m_req) check("int_vec", 32'(int_vec), 32'(m_vec));
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check({"lit_", name}, act, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    lit("rst_req", 32'(int_req), 0);
    lit("rst_pend", 32'(pend), 0);
    lit("rst_svc", 32'(in_svc), 0);
    lit("rst_vec", 32'(int_vec), 0);

    // single edge source, latency and ack
    ea = 1; ie = 5'h1F; ip = 5'h00; it_mode = 5'h1F; irq_in = 0;
    rst_n = 1'b1; tick();
    irq_in = 5'b00100; tick();
    lit("lat_pend", 32'(pend), 32'h4);
    lit("lat_req0", 32'(int_req), 0);
    tick();
    lit("lat_req1", 32'(int_req), 1);
    lit("lat_vec", 32'(int_vec), 2);
    int_ack = 1; tick(); int_ack = 0;
    lit("ack_pend", 32'(pend), 0);
    lit("ack_svc", 32'(in_svc), 1);
    lit("ack_req", 32'(int_req), 0);
    reti = 1; tick(); reti = 0;
    lit("reti_svc", 32'(in_svc), 0);
    irq_in = 0; tick();

    // two simultaneous edges: lowest index first
    irq_in = 5'b01010; tick(); tick();
    lit("two_vec1", 32'(int_vec), 1);
    int_ack = 1; tick(); int_ack = 0;
    lit("two_blk", 32'(int_req), 0);
    reti = 1; tick(); reti = 0;
    lit("two_req", 32'(int_req), 1);
    lit("two_vec3", 32'(int_vec), 3);
    int_ack = 1; tick(); int_ack = 0;
    reti = 1; tick(); reti = 0;
    irq_in = 0; tick();

    // low source 0 in service, high-priority source 4 arrives
    ip = 5'b10000;
    irq_in = 5'b00001; tick(); tick();
    int_ack = 1; tick(); int_ack = 0;
    lit("pre_svc", 32'(in_svc), 1);
    irq_in = 5'b10001; tick(); tick();
`ifdef INT_CTL_NEST_EN
    lit("nest_req", 32'(int_req), 1);
    lit("nest_vec", 32'(int_vec), 4);
    int_ack = 1; tick(); int_ack = 0;
    lit("nest_svc11", 32'(in_svc), 3);
    reti = 1; tick();
    lit("nest_svc01", 32'(in_svc), 1);
    tick(); reti = 0;
    lit("nest_svc00", 32'(in_svc), 0);
`else
    lit("flat_blk0", 32'(int_req), 0);
    tick();
    lit("flat_blk1", 32'(int_req), 0);
    reti = 1; tick(); reti = 0;
    lit("flat_req", 32'(int_req), 1);
    lit("flat_vec", 32'(int_vec), 4);
    int_ack = 1; tick(); int_ack = 0;
    reti = 1; tick(); reti = 0;
    lit("flat_svc", 32'(in_svc), 0);
`endif
    irq_in = 0; ip = 0; tick();

    // level source 3 held high across ack+reti
    it_mode = 5'b10111;
    irq_in = 5'b01000; tick(); tick();
    lit("lvl_vec", 32'(int_vec), 3);
    int_ack = 1; tick(); int_ack = 0;
    lit("lvl_pend", 32'(pend), 32'h8);
    reti = 1; tick(); reti = 0;
    lit("lvl_rereq", 32'(int_req), 1);
    lit("lvl_vec2", 32'(int_vec), 3);
    irq_in = 0; int_ack = 1; tick(); int_ack = 0;
    reti = 1; tick(); reti = 0;
    it_mode = 5'h1F; tick();

    // ea drop, then reset mid-service, then edge already high after reset
    irq_in = 5'b00100; tick(); tick();
    ea = 0; tick();
    lit("ea_req", 32'(int_req), 0);
    lit("ea_pend", 32'(pend), 32'h4);
    ea = 1; tick();
    int_ack = 1; tick(); int_ack = 0;
    lit("mid_svc", 32'(in_svc), 1);
    rst_n = 0; tick();
    lit("mid_rst_svc", 32'(in_svc), 0);
    lit("mid_rst_pend", 32'(pend), 0);
    lit("mid_rst_req", 32'(int_req), 0);
    rst_n = 1; tick();
    lit("post_rst_pend", 32'(pend), 32'h4);
    irq_in = 0; tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N_SRC; i++)
        if ($urandom_range(0, 5) == 0) irq_in[i] = ~irq_in[i];
      if (c % 50 == 0) ie = N_SRC'($urandom_range(0, 31)) | 5'b00001;
      if (c % 30 == 0) ip = N_SRC'($urandom_range(0, 31));
      if (c % 100 == 0) it_mode = N_SRC'($urandom_range(0, 31));
      ea      = ($urandom_range(0, 15) != 0);
      int_ack = ($urandom_range(0, 1) == 1);
      reti    = ($urandom_range(0, 4) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
